sdram_user_emu: RTL and testbench



---
 rtl/sdram_user_emu_if.sv | 30 +++
 rtl/sdram_user_emu.sv | 169 ++++++++++++++++
 tb/tb_sdram_user_emu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_user_emu_if.sv
// rtl/sdram_user_emu_if.sv - user-side burst interface bundle shared by the SDRAM controller and its emulator
interface sdram_user_emu_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 9
);
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [23:0]       sys_wraddr;
    logic [23:0]       sys_rdaddr;
    logic [LEN_W-1:0]  sdwr_byte;
    logic [LEN_W-1:0]  sdrd_byte;
    logic [DATA_W-1:0] sys_data_in;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;
    logic [DATA_W-1:0] sys_data_out;
    logic              sdram_init_done;
    logic              busy;

    modport master (
        output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
               sdwr_byte, sdrd_byte, sys_data_in,
        input  sdram_wr_ack, sdram_rd_ack, sys_data_out, sdram_init_done, busy
    );

    modport slave (
        input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
               sdwr_byte, sdrd_byte, sys_data_in,
        output sdram_wr_ack, sdram_rd_ack, sys_data_out, sdram_init_done, busy
    );
endinterface

// File: rtl/sdram_user_emu.sv
// rtl/sdram_user_emu.sv - block-RAM stand-in for the SDRAM controller user burst port; SDRAM_EMU_REFRESH_EN adds refresh stalls
module sdram_user_emu #(
    parameter int MEM_AW         = 10,
    parameter int DATA_W         = 16,
    parameter int LEN_W          = 9,
    parameter int INIT_CYCLES    = 200,
    parameter int ACK_LATENCY    = 3,
    parameter int REFRESH_PERIOD = 780
) (
    input logic              clk,
    input logic              reset,
    sdram_user_emu_if.slave  bus
);
    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_WR_LAT   = 3'd2;
    localparam logic [2:0] S_WR_BURST = 3'd3;
    localparam logic [2:0] S_RD_LAT   = 3'd4;
    localparam logic [2:0] S_RD_BURST = 3'd5;
    localparam logic [2:0] S_RELEASE  = 3'd6;
`ifdef SDRAM_EMU_REFRESH_EN
    localparam logic [2:0] S_REFRESH  = 3'd7;
`endif

    localparam int              INIT_W    = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [3:0]      LAT_START = 4'(ACK_LATENCY - 1);

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    logic [2:0]        state, state_nx;
    logic [INIT_W-1:0] init_cnt;
    logic [3:0]        lat_cnt;
    logic [LEN_W-1:0]  burst_len;
    logic [MEM_AW-1:0] addr;
    logic              svc_wr;
    logic              ref_hold;

    wire lat_done   = (lat_cnt == 4'd0);
    wire len_zero   = (burst_len == '0);
    wire burst_last = (burst_len == LEN_W'(1));
    wire req_low    = svc_wr ? !bus.sdram_wr_req : !bus.sdram_rd_req;
    wire accept_wr  = (state == S_IDLE) && !ref_hold && bus.sdram_wr_req;
    wire accept_rd  = (state == S_IDLE) && !ref_hold && !bus.sdram_wr_req && bus.sdram_rd_req;

`ifdef SDRAM_EMU_REFRESH_EN
    localparam int               REF_W    = $clog2(REFRESH_PERIOD + 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_PERIOD - 1);

    logic [REF_W-1:0] ref_cnt;
    logic             ref_pend;
    logic [2:0]       ref_left;

    assign ref_hold = ref_pend;

    // Free-running tick; a pending refresh is only consumed when IDLE hands off to REFRESH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
            ref_left <= 3'd0;
        end else begin
            ref_cnt  <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
            ref_pend <= (ref_cnt == REF_LAST) || (ref_pend && (state != S_IDLE));
            if (state == S_IDLE && ref_pend)
                ref_left <= 3'd7;
            else if (state == S_REFRESH && ref_left != 3'd0)
                ref_left <= ref_left - 1'b1;
        end
    end
`else
    assign ref_hold = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:     if (init_cnt == INIT_LAST) state_nx = S_IDLE;
            S_IDLE: begin
                if (accept_wr)      state_nx = S_WR_LAT;
                else if (accept_rd) state_nx = S_RD_LAT;
`ifdef SDRAM_EMU_REFRESH_EN
                if (ref_hold)       state_nx = S_REFRESH;
`endif
            end
            S_WR_LAT:   if (lat_done) state_nx = len_zero ? S_RELEASE : S_WR_BURST;
            S_WR_BURST: if (burst_last) state_nx = S_RELEASE;
            S_RD_LAT:   if (lat_done) state_nx = len_zero ? S_RELEASE : S_RD_BURST;
            S_RD_BURST: if (burst_last) state_nx = S_RELEASE;
            S_RELEASE:  if (req_low) state_nx = S_IDLE;
`ifdef SDRAM_EMU_REFRESH_EN
            S_REFRESH:  if (ref_left == 3'd0) state_nx = S_IDLE;
`endif
            default:    state_nx = S_INIT;
        endcase
    end

    // Reads are issued on the same edge that raises the ack, so the RAM output register lines up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_INIT;
            init_cnt            <= '0;
            lat_cnt             <= 4'd0;
            burst_len           <= '0;
            addr                <= '0;
            svc_wr              <= 1'b0;
            bus.sdram_wr_ack    <= 1'b0;
            bus.sdram_rd_ack    <= 1'b0;
            bus.sys_data_out    <= '0;
            bus.sdram_init_done <= 1'b0;
            bus.busy            <= 1'b1;
        end else begin
            state    <= state_nx;
            bus.busy <= (state_nx != S_IDLE);
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (state_nx == S_IDLE) bus.sdram_init_done <= 1'b1;
                end
                S_IDLE: begin
                    if (accept_wr) begin
                        addr      <= bus.sys_wraddr[MEM_AW-1:0];
                        burst_len <= bus.sdwr_byte;
                        svc_wr    <= 1'b1;
                        lat_cnt   <= LAT_START;
                    end else if (accept_rd) begin
                        addr      <= bus.sys_rdaddr[MEM_AW-1:0];
                        burst_len <= bus.sdrd_byte;
                        svc_wr    <= 1'b0;
                        lat_cnt   <= LAT_START;
                    end
                end
                S_WR_LAT: begin
                    if (!lat_done) lat_cnt <= lat_cnt - 1'b1;
                    else           bus.sdram_wr_ack <= !len_zero;
                end
                S_WR_BURST: begin
                    addr      <= addr + 1'b1;
                    burst_len <= burst_len - 1'b1;
                    if (burst_last) bus.sdram_wr_ack <= 1'b0;
                end
                S_RD_LAT: begin
                    if (!lat_done) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else if (!len_zero) begin
                        bus.sdram_rd_ack <= 1'b1;
                        bus.sys_data_out <= mem[addr];
                        addr             <= addr + 1'b1;
                    end
                end
                S_RD_BURST: begin
                    burst_len <= burst_len - 1'b1;
                    if (burst_last) begin
                        bus.sdram_rd_ack <= 1'b0;
                    end else begin
                        bus.sys_data_out <= mem[addr];
                        addr             <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_WR_BURST)
            mem[addr] <= bus.sys_data_in;
    end
endmodule

// File: tb/tb_sdram_user_emu.sv
// tb/tb_sdram_user_emu.sv - directed scoreboard bench for sdram_user_emu
`timescale 1ns/1ps
module tb_sdram_user_emu;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdram_user_emu_if #(.DATA_W(16), .LEN_W(9)) bus ();
    sdram_user_emu dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc, wr_acks, rd_acks, first_wr, first_rd, last_wr, last_rd, gaps, wr_addr_m;
    logic [15:0] wr_base;
    logic [15:0] model [0:1023];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_cmd();
        cyc = -1; wr_acks = 0; rd_acks = 0; gaps = 0;
        first_wr = -1; first_rd = -1; last_wr = -1; last_rd = -1;
    endtask

    task automatic push_reads(input int a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model[10'(a + i)]);
    endtask

    // Each cycle: present the next write word, record write acks into the model, score read acks.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc++;
            bus.sys_data_in = wr_base + 16'(wr_acks);
            if (bus.sdram_wr_ack === 1'b1) begin
                if (first_wr < 0) first_wr = cyc;
                else if (last_wr != cyc - 1) gaps++;
                last_wr = cyc;
                model[10'(wr_addr_m + wr_acks)] = bus.sys_data_in;
                wr_acks++;
            end
            if (bus.sdram_rd_ack === 1'b1) begin
                if (first_rd < 0) first_rd = cyc;
                else if (last_rd != cyc - 1) gaps++;
                last_rd = cyc;
                if (exp_q.size() == 0) check("rd_unexpected_ack", 32'd1, 32'd0);
                else check("rd_data", {16'd0, bus.sys_data_out}, {16'd0, exp_q.pop_front()});
                rd_acks++;
            end
        end
    endtask

    task automatic wait_init(input string tag);
        int early = 0;
        for (int i = 0; i < 199; i++) begin
            tick();
            if (bus.sdram_init_done !== 1'b0) early++;
        end
        check({tag, "_init_early"}, early, 0);
        tick();
        check({tag, "_init_done"}, bus.sdram_init_done, 1);
        check({tag, "_idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        bus.sdram_wr_req = 1'b0; bus.sdram_rd_req = 1'b0;
        bus.sys_wraddr = '0; bus.sys_rdaddr = '0;
        bus.sdwr_byte = '0; bus.sdrd_byte = '0; bus.sys_data_in = '0;
        wr_base = 16'h0; wr_addr_m = 0;
        begin_cmd();

        // Reset values and init timing
        tick(); tick();
        check("rst_wr_ack", bus.sdram_wr_ack, 0);
        check("rst_rd_ack", bus.sdram_rd_ack, 0);
        check("rst_data_out", bus.sys_data_out, 0);
        check("rst_init_done", bus.sdram_init_done, 0);
        check("rst_busy", bus.busy, 1);
        reset = 1'b0;
        wait_init("t1");

        // Write burst at 0, latched inputs disturbed after acceptance
        begin_cmd(); wr_addr_m = 0; wr_base = 16'h5500; bus.sys_data_in = 16'h5500;
        bus.sys_wraddr = 24'h000000; bus.sdwr_byte = 9'd8; bus.sdram_wr_req = 1'b1;
        run(1);
        check("t2_busy_accept", bus.busy, 1);
        bus.sys_wraddr = 24'h000123; bus.sdwr_byte = 9'd2;
        run(14);
        check("t2_wr_acks", wr_acks, 8);
        check("t2_first_ack", first_wr, 3);
        check("t2_gaps", gaps, 0);
        bus.sdram_wr_req = 1'b0;
        run(2);
        check("t2_busy_end", bus.busy, 0);

        // Read burst back
        begin_cmd(); push_reads(0, 8);
        bus.sys_rdaddr = 24'h000000; bus.sdrd_byte = 9'd8; bus.sdram_rd_req = 1'b1;
        run(1);
        bus.sys_rdaddr = 24'h000040; bus.sdrd_byte = 9'd1;
        run(14);
        check("t3_rd_acks", rd_acks, 8);
        check("t3_first_ack", first_rd, 3);
        check("t3_gaps", gaps, 0);
        check("t3_queue_left", exp_q.size(), 0);
        bus.sdram_rd_req = 1'b0;
        run(2);
        check("t3_busy_end", bus.busy, 0);

        // Simultaneous requests: write wins, held requests not re-serviced
        begin_cmd(); wr_addr_m = 'h100; wr_base = 16'hA000; bus.sys_data_in = 16'hA000;
        push_reads(0, 2);
        bus.sys_wraddr = 24'h000100; bus.sdwr_byte = 9'd2;
        bus.sys_rdaddr = 24'h000000; bus.sdrd_byte = 9'd2;
        bus.sdram_wr_req = 1'b1; bus.sdram_rd_req = 1'b1;
        run(12);
        check("t4_wr_acks", wr_acks, 2);
        check("t4_rd_held_off", rd_acks, 0);
        check("t4_first_wr", first_wr, 3);
        check("t4_busy_release", bus.busy, 1);
        bus.sdram_wr_req = 1'b0;
        run(10);
        check("t4_rd_acks", rd_acks, 2);
        check("t4_queue_left", exp_q.size(), 0);
        run(6);
        check("t4_no_repeat_rd", rd_acks, 2);
        check("t4_no_repeat_wr", wr_acks, 2);
        bus.sdram_rd_req = 1'b0;
        run(2);
        check("t4_busy_end", bus.busy, 0);

        // Address wrap with upper address bits truncated
        begin_cmd(); wr_addr_m = 'h3FE; wr_base = 16'hC000; bus.sys_data_in = 16'hC000;
        bus.sys_wraddr = 24'hFF03FE; bus.sdwr_byte = 9'd4; bus.sdram_wr_req = 1'b1;
        run(12);
        check("t5_wr_acks", wr_acks, 4);
        bus.sdram_wr_req = 1'b0;
        run(2);
        begin_cmd(); push_reads('h3FE, 4);
        bus.sys_rdaddr = 24'h0003FE; bus.sdrd_byte = 9'd4; bus.sdram_rd_req = 1'b1;
        run(12);
        check("t5_rd_acks", rd_acks, 4);
        check("t5_queue_left", exp_q.size(), 0);
        bus.sdram_rd_req = 1'b0;
        run(2);

        // Zero-length burst
        begin_cmd(); wr_addr_m = 5; wr_base = 16'hDEAD;
        bus.sys_wraddr = 24'h000005; bus.sdwr_byte = 9'd0; bus.sdram_wr_req = 1'b1;
        run(10);
        check("t5_len0_acks", wr_acks, 0);
        check("t5_len0_busy", bus.busy, 1);
        bus.sdram_wr_req = 1'b0;
        run(2);
        check("t5_len0_idle", bus.busy, 0);

        // Reset during the 4th write ack
        begin_cmd(); wr_addr_m = 'h200; wr_base = 16'h7700; bus.sys_data_in = 16'h7700;
        bus.sys_wraddr = 24'h000200; bus.sdwr_byte = 9'd8; bus.sdram_wr_req = 1'b1;
        for (int i = 0; i < 20 && wr_acks < 4; i++) run(1);
        check("t6_reach_4th", wr_acks, 4);
        reset = 1'b1;
        #1;
        check("t6_ack_drop", bus.sdram_wr_ack, 0);
        check("t6_init_drop", bus.sdram_init_done, 0);
        check("t6_busy", bus.busy, 1);
        bus.sdram_wr_req = 1'b0;
        tick();
        reset = 1'b0;
        wait_init("t6");
        begin_cmd(); push_reads('h200, 3);
        bus.sys_rdaddr = 24'h000200; bus.sdrd_byte = 9'd3; bus.sdram_rd_req = 1'b1;
        run(10);
        check("t6_rd_acks", rd_acks, 3);
        check("t6_queue_left", exp_q.size(), 0);
        bus.sdram_rd_req = 1'b0;
        run(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
